// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared types, AES length constants and tkeep helper for the
//                AES-256 CTR framing stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int unsigned c_AES_KEY_BITS   = 256;
    localparam int unsigned c_AES_BLOCK_BITS = 128;

    // One-hot frame builder states
    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0001,
        ST_KEY     = 4'b0010,
        ST_COUNTER = 4'b0100,
        ST_PAYLOAD = 4'b1000
    } state_t;

    // True when keep is a non-empty run of ones starting at bit 0.
    // Narrower tkeep vectors are zero-extended by the caller.
    function automatic logic f_tkeep_contiguous(input logic [15:0] keep);
        return (keep != 16'h0000) && (((keep + 16'h0001) & keep) == 16'h0000);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_if.sv
`default_nettype none
// ============================================================================
//  Module      : axis_if
//  Description : AXI-Stream bundle (tdata, tkeep, tlast, tuser, tvalid,
//                tready) with master and slave views.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axis_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;
    logic                    tuser;
    logic                    tvalid;
    logic                    tready;

    modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/aes_tkeep_checker.sv
`default_nettype none
// ============================================================================
//  Module      : aes_tkeep_checker
//  Description : Sticky tkeep legality flag for payload beats. Non-final beats
//                must be full; the final beat must be a low-aligned run.
//                Only built when AES_FRAME_TKEEP_CHECK_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`ifdef AES_FRAME_TKEEP_CHECK_EN
module aes_tkeep_checker
    import aes_pkg::*;
#(
    parameter int KEEP_W = 8
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Beat_valid,
    input  logic [KEEP_W-1:0] Tkeep,
    input  logic              Tlast,
    output logic              Err
);

    logic w_bad;
    logic r_err;

    assign w_bad = Beat_valid &
                   (Tlast ? !f_tkeep_contiguous(16'(Tkeep)) : (Tkeep != {KEEP_W{1'b1}}));

    // Latch any illegal beat until the next reset
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_err <= 1'b0;
        end else if (w_bad) begin
            r_err <= 1'b1;
        end
    end

    assign Err = r_err;

endmodule
`endif
`default_nettype wire

// File: rtl/aes_ctr_frame_builder.sv
`default_nettype none
// ============================================================================
//  Module      : aes_ctr_frame_builder
//  Description : Builds the CTR core input stream: key words, counter words,
//                then the payload passed through combinationally.
//                Optional macro AES_FRAME_TKEEP_CHECK_EN enables the sticky
//                payload tkeep checker driving Err (tied 0 otherwise).
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_ctr_frame_builder
    import aes_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                        Clk,
    input  logic                        Rst_n,
    input  logic                        Cfg_valid,
    output logic                        Cfg_ready,
    input  logic [c_AES_KEY_BITS-1:0]   Cfg_key,
    input  logic [c_AES_BLOCK_BITS-1:0] Cfg_iv,
    input  logic                        Cfg_encrypt,
    axis_if.slave                       S_axis,
    axis_if.master                      M_axis,
    output logic [15:0]                 Frame_cnt,
    output logic                        Err
);

    localparam int KEY_WORDS = c_AES_KEY_BITS / DATA_WIDTH;
    localparam int CTR_WORDS = c_AES_BLOCK_BITS / DATA_WIDTH;
    localparam int CNT_W     = $clog2(KEY_WORDS);
    localparam int KEEP_W    = DATA_WIDTH / 8;

    localparam logic [CNT_W-1:0] c_KEY_LAST = CNT_W'(KEY_WORDS - 1);
    localparam logic [CNT_W-1:0] c_CTR_LAST = CNT_W'(CTR_WORDS - 1);

    state_t                      r_state;
    state_t                      w_state_next;
    logic [CNT_W-1:0]            r_cnt;
    logic [c_AES_KEY_BITS-1:0]   r_key;
    logic [c_AES_BLOCK_BITS-1:0] r_iv;
    logic                        r_encrypt;
    logic [15:0]                 r_frame_cnt;
    logic                        w_m_hs;
    logic                        w_pay_hs;

    assign w_m_hs   = M_axis.tvalid & M_axis.tready;
    assign w_pay_hs = (r_state == ST_PAYLOAD) & S_axis.tvalid & M_axis.tready;

    // State register
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: header phases advance on their last word, payload on tlast
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (Cfg_valid)                       w_state_next = ST_KEY;
            ST_KEY:     if (w_m_hs && r_cnt == c_KEY_LAST)   w_state_next = ST_COUNTER;
            ST_COUNTER: if (w_m_hs && r_cnt == c_CTR_LAST)   w_state_next = ST_PAYLOAD;
            ST_PAYLOAD: if (w_pay_hs && S_axis.tlast)        w_state_next = ST_IDLE;
            default:                                         w_state_next = ST_IDLE;
        endcase
    end

    // Outputs: header word mux in KEY/COUNTER, straight wires in PAYLOAD
    always_comb begin
        Cfg_ready     = 1'b0;
        S_axis.tready = 1'b0;
        M_axis.tvalid = 1'b0;
        M_axis.tdata  = '0;
        M_axis.tkeep  = '0;
        M_axis.tlast  = 1'b0;
        M_axis.tuser  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                Cfg_ready = 1'b1;
            end
            ST_KEY: begin
                M_axis.tvalid = 1'b1;
                M_axis.tdata  = r_key[int'(r_cnt)*DATA_WIDTH +: DATA_WIDTH];
                M_axis.tkeep  = {KEEP_W{1'b1}};
                M_axis.tuser  = r_encrypt;
            end
            ST_COUNTER: begin
                M_axis.tvalid = 1'b1;
                M_axis.tdata  = r_iv[int'(r_cnt)*DATA_WIDTH +: DATA_WIDTH];
                M_axis.tkeep  = {KEEP_W{1'b1}};
                M_axis.tuser  = r_encrypt;
            end
            ST_PAYLOAD: begin
                M_axis.tvalid = S_axis.tvalid;
                S_axis.tready = M_axis.tready;
                M_axis.tdata  = S_axis.tdata;
                M_axis.tkeep  = S_axis.tkeep;
                M_axis.tlast  = S_axis.tlast;
                M_axis.tuser  = r_encrypt;
            end
            default: ;
        endcase
    end

    // Capture configuration in IDLE and step the header word counter
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_cnt     <= '0;
            r_key     <= '0;
            r_iv      <= '0;
            r_encrypt <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (Cfg_valid) begin
                        r_key     <= Cfg_key;
                        r_iv      <= Cfg_iv;
                        r_encrypt <= Cfg_encrypt;
                        r_cnt     <= '0;
                    end
                end
                ST_KEY: begin
                    if (w_m_hs) begin
                        r_cnt <= (r_cnt == c_KEY_LAST) ? '0 : r_cnt + CNT_W'(1);
                    end
                end
                ST_COUNTER: begin
                    if (w_m_hs) begin
                        r_cnt <= (r_cnt == c_CTR_LAST) ? '0 : r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Count frames whose final payload beat has been handed over
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_frame_cnt <= '0;
        end else if (w_pay_hs && S_axis.tlast) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign Frame_cnt = r_frame_cnt;

`ifdef AES_FRAME_TKEEP_CHECK_EN
    aes_tkeep_checker #(
        .KEEP_W (KEEP_W)
    ) u_tkeep_checker (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Beat_valid (w_pay_hs),
        .Tkeep      (S_axis.tkeep),
        .Tlast      (S_axis.tlast),
        .Err        (Err)
    );
`else
    assign Err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/aes_ctr_frame_builder.md
# aes_ctr_frame_builder

Upstream framing stage for the AES-256 CTR core. It takes a per-frame configuration (key, initial counter block, direction) plus a raw payload AXI-Stream and emits one framed stream on M_axis: key words, then counter words, then the payload passed through. The output is the exact beat sequence the CTR core's slave port consumes. The block sits between the DMA/payload source and the CTR core.

## Interface
- DATA_WIDTH, 64, S_axis/M_axis tdata width; one of 32, 64, 128.
- Clk  in  1  clock; all logic on rising edge.
- Rst_n  in  1  reset, synchronous, active-low.
- Cfg_valid  in  1  configuration offered.
- Cfg_ready  out  1  configuration accepted this cycle when high with Cfg_valid.
- Cfg_key  in  256  AES-256 key; byte 0 at bits [7:0].
- Cfg_iv  in  128  initial counter block; byte 0 (first on wire) at bits [7:0].
- Cfg_encrypt  in  1  direction flag, driven on tuser of every beat of the frame.
- S_axis  axis_if.slave  DATA_WIDTH  payload (tdata, tkeep, tlast, tvalid, tready).
- M_axis  axis_if.master  DATA_WIDTH  framed stream to CTR core (tdata, tkeep, tlast, tuser, tvalid, tready).
- Frame_cnt  out  16  completed frames, wraps 0xFFFF→0.
- Err  out  1  sticky tkeep error (only with macro, else tied 0).

## Operation
- KEY_WORDS = 256/DATA_WIDTH; CTR_WORDS = 128/DATA_WIDTH; beat counter width $clog2(KEY_WORDS).
- States (one-hot): ST_IDLE, ST_KEY, ST_COUNTER, ST_PAYLOAD.
- ST_IDLE: Cfg_ready=1, M_axis.tvalid=0, S_axis.tready=0. On Cfg_valid&Cfg_ready, capture key/iv/encrypt into registers, cnt←0, go ST_KEY.
- ST_KEY: M_axis.tvalid=1, tdata=key_reg[cnt*DATA_WIDTH +: DATA_WIDTH], tkeep all ones, tlast=0. Advance cnt on M handshake; last word (cnt==KEY_WORDS-1) handshake → cnt←0, ST_COUNTER.
- ST_COUNTER: same, with iv_reg; last word handshake → ST_PAYLOAD.
- ST_PAYLOAD: combinational pass-through. M.tvalid=S.tvalid, S.tready=M.tready, tdata/tkeep/tlast copied, tuser=encrypt_reg. Handshake with S.tlast=1 → Frame_cnt+1, ST_IDLE.
- Cfg_ready=0 and S_axis.tready=0 outside the states listed above. Config inputs are ignored while not in ST_IDLE.
- M_axis.tvalid never drops without a handshake. tdata is held stable while tvalid&!tready.
- Reset (Rst_n=0 at an edge), including mid-frame: state←ST_IDLE, cnt←0, key/iv/encrypt regs←0, Frame_cnt←0, Err←0. Outputs from the next cycle: Cfg_ready=1, M.tvalid=0, M.tdata/tkeep/tlast/tuser=0, S.tready=0.

## Timing
- Config handshake at cycle N → first key beat valid at N+1.
- With M.tready held high, the header takes KEY_WORDS+CTR_WORDS cycles (6 at 64 bit). The first payload beat may transfer at N+1+6.
- Payload adds zero latency and zero bubbles: the combinational path runs S→M in both directions.
- Last payload handshake at cycle L → ST_IDLE at L+1. The next config can be accepted at L+1, so there is a minimum 1-cycle gap between frames.
- Frame_cnt updates at L+1.

## Configuration
- AES_FRAME_TKEEP_CHECK_EN defined: in ST_PAYLOAD, every handshake beat is checked.
  - A non-final beat (tlast=0) with tkeep not all ones sets Err.
  - A final beat whose tkeep is not a contiguous low-aligned run (including tkeep=0) sets Err.
  - Err is sticky until reset. The data still passes through unchanged.
- Undefined: no checker logic; Err tied 0.

## Structure
- A shared package (aes_pkg) holds the state enum type, the AES key and block length constants (256/128), and a helper function for the contiguous-tkeep check.
- One sub-module is natural: aes_tkeep_checker, instantiated only under the macro.
- The header word mux and the FSM stay in the top module.

## Test plan
- DATA_WIDTH=64, key=0x1F..00 (byte i = i), iv=0xFF..F0, 3-beat payload with tready=1 → M beats: key words 0x0706050403020100 … 0x1F1E1D1C1B1A1918, then iv words, then 3 payload beats. Last beat has tlast=1; Frame_cnt=1.
- Random M.tready back-pressure (50%) over 100 frames → beat sequence identical to the no-stall run, tdata stable while stalled, Frame_cnt=100.
- Cfg_valid held high during ST_PAYLOAD with changing Cfg_key → not accepted; the next frame uses the key presented at the next ST_IDLE.
- Rst_n low for 1 cycle mid-ST_KEY (beat 2) → next cycle Cfg_ready=1, M.tvalid=0, Frame_cnt=0. The following frame starts again at key word 0.
- Single-beat payload with tlast=1, tkeep=0x0F → passed through with tkeep 0x0F, then ST_IDLE. With the macro, Err stays 0.
- Macro on: non-last payload beat with tkeep=0xFE → Err=1 at the next cycle and stays 1 across later frames until reset.
